// File: rtl/queue_ctrl_16x46_pkg.sv
// Shared sizing constants and types for the 16x46 macro-backed queue.
// Pointer and count widths follow from the macro depth.
package queue_16x46_pkg;

  localparam int DEPTH = 16;
  localparam int WIDTH = 46;
  localparam int PTR_W = 4;
  localparam int CNT_W = 5;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [WIDTH-1:0] data_t;

endpackage

// File: rtl/ram_16x46.sv
// 16x46 storage macro model: one synchronous write port W0 and one combinational read port R0.
// Contents are never reset.
module ram_16x46
  import queue_16x46_pkg::*;
(
  input  logic  R0_clk,
  input  logic  R0_en,
  input  ptr_t  R0_addr,
  output data_t R0_data,
  input  logic  W0_clk,
  input  logic  W0_en,
  input  ptr_t  W0_addr,
  input  data_t W0_data
);

  data_t mem [DEPTH];

  // The read port is asynchronous, so its clock pin has no function in this model.
  logic unused_r0_clk;
  assign unused_r0_clk = R0_clk;

  always_ff @(posedge W0_clk) begin
    if (W0_en) begin
      mem[W0_addr] <= W0_data;
    end
  end

  assign R0_data = R0_en ? mem[R0_addr] : '0;

endmodule

// File: rtl/queue_ctrl_16x46.sv
// Ready/valid FIFO controller driving the ram_16x46 macro: no flow-through, no pipe bypass,
// with a synchronous flush and an occupancy count.
module queue_ctrl_16x46
  import queue_16x46_pkg::*;
#(
  parameter int DEPTH_P = DEPTH,
  parameter int WIDTH_P = WIDTH
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  enq_valid,
  output logic  enq_ready,
  input  data_t enq_bits,
  output logic  deq_valid,
  input  logic  deq_ready,
  output data_t deq_bits,
  input  logic  flush,
  output cnt_t  count
);

  if (DEPTH_P != 16 || WIDTH_P != 46) begin : g_bad_geometry
    $error("queue_ctrl_16x46 only supports the 16x46 macro geometry");
  end

  ptr_t enq_ptr_q, enq_ptr_d;
  ptr_t deq_ptr_q, deq_ptr_d;
  logic maybe_full_q, maybe_full_d;

  logic ptr_match;
  logic empty;
  logic full;
  logic do_enq;
  logic do_deq;
  ptr_t ptr_diff;

  // Status depends only on registered state, so ready/valid never loop through the handshake.
  assign ptr_match = (enq_ptr_q == deq_ptr_q);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match & maybe_full_q;
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign do_enq    = enq_valid & enq_ready;
  assign do_deq    = deq_ready & deq_valid;
  assign ptr_diff  = enq_ptr_q - deq_ptr_q;
  assign count     = {full, ptr_diff};

  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (flush) begin
      enq_ptr_d    = '0;
      deq_ptr_d    = '0;
      maybe_full_d = 1'b0;
    end else begin
      if (do_enq) begin
        enq_ptr_d = enq_ptr_q + ptr_t'(1);
      end
      if (do_deq) begin
        deq_ptr_d = deq_ptr_q + ptr_t'(1);
      end
      if (do_enq != do_deq) begin
        maybe_full_d = do_enq;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // A flushed enqueue must not disturb storage, so the write enable is masked too.
  ram_16x46 u_ram (
    .R0_clk  (clock),
    .R0_en   (1'b1),
    .R0_addr (deq_ptr_q),
    .R0_data (deq_bits),
    .W0_clk  (clock),
    .W0_en   (do_enq & ~flush),
    .W0_addr (enq_ptr_q),
    .W0_data (enq_bits)
  );

  always @(posedge clock) begin
    if (reset) begin
      assert (count <= cnt_t'(DEPTH));
      assert (!$isunknown({enq_ready, deq_valid}));
    end
  end

endmodule

// File: tb/tb_queue_ctrl_16x46.sv
// Directed, table-driven bench for queue_ctrl_16x46 with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
module tb_queue_ctrl_16x46;
  import queue_16x46_pkg::*;

  logic  clock = 1'b0;
  logic  reset;
  logic  enq_valid;
  logic  enq_ready;
  data_t enq_bits;
  logic  deq_valid;
  logic  deq_ready;
  data_t deq_bits;
  logic  flush;
  cnt_t  count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic  enqValid;
    data_t enqBits;
    logic  deqReady;
    logic  expEnqReady;
    logic  expDeqValid;
    cnt_t  expCount;
    logic  checkBits;
    data_t expBits;
  } vector_t;

  vector_t vectors[5];

  queue_ctrl_16x46 dut (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_bits  (enq_bits),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_bits  (deq_bits),
    .flush     (flush),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ev, input data_t eb, input logic dr, input logic fl);
    enq_valid = ev;
    enq_bits  = eb;
    deq_ready = dr;
    flush     = fl;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic checkStatus(input string name, input logic er, input logic dv, input cnt_t cnt);
    #1;
    checkOutput({name, ".enq_ready"}, 64'(enq_ready), 64'(er));
    checkOutput({name, ".deq_valid"}, 64'(deq_valid), 64'(dv));
    checkOutput({name, ".count"}, 64'(count), 64'(cnt));
  endtask

  task automatic fillQueue(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, data_t'(base + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors[0] = '{1'b1, 46'h0000_0000_0001, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 46'h0};
    vectors[1] = '{1'b1, 46'h3FFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 46'h1};
    vectors[2] = '{1'b0, 46'h0,              1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 46'h1};
    vectors[3] = '{1'b0, 46'h0,              1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 46'h3FFF_FFFF_FFFF};
    vectors[4] = '{1'b0, 46'h0,              1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 46'h0};

    // Reset held for three cycles, then idle cycles after release.
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkStatus("reset_hold", 1'b1, 1'b0, 5'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkStatus("reset_idle", 1'b1, 1'b0, 5'd0);
    end

    // Two-entry enqueue then drain, from the vector table.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vectors[i].enqValid, vectors[i].enqBits, vectors[i].deqReady, 1'b0);
      checkStatus($sformatf("vec%0d", i), vectors[i].expEnqReady, vectors[i].expDeqValid,
                  vectors[i].expCount);
      if (vectors[i].checkBits) begin
        checkOutput($sformatf("vec%0d.deq_bits", i), 64'(deq_bits), 64'(vectors[i].expBits));
      end
      tick();
    end

    // Fill to 16, reject a 17th, drain in order.
    fillQueue(16, 0);
    checkStatus("full", 1'b0, 1'b1, 5'd16);
    applyStimulus(1'b1, 46'h99, 1'b0, 1'b0);
    tick();
    checkStatus("full_reject", 1'b0, 1'b1, 5'd16);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      #1;
      checkOutput($sformatf("drain%0d.deq_bits", i), 64'(deq_bits), 64'(i));
      tick();
    end
    checkStatus("drained", 1'b1, 1'b0, 5'd0);

    // Steady occupancy of 8 with simultaneous enq/deq across pointer wrap.
    fillQueue(8, 100);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, data_t'(200 + k), 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("steady%0d.deq_bits", k), 64'(deq_bits),
                  (k < 8) ? 64'(100 + k) : 64'(200 + k - 8));
      checkOutput($sformatf("steady%0d.count", k), 64'(count), 64'd8);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput($sformatf("steady_drain%0d.deq_bits", k), 64'(deq_bits), 64'(212 + k));
      tick();
    end
    checkStatus("steady_empty", 1'b1, 1'b0, 5'd0);

    // Flush with a concurrent enqueue drops everything, including that enqueue.
    fillQueue(5, 'h50);
    checkStatus("pre_flush", 1'b1, 1'b1, 5'd5);
    applyStimulus(1'b1, 46'h77, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkStatus("post_flush", 1'b1, 1'b0, 5'd0);
    applyStimulus(1'b1, 46'h2A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkStatus("after_flush_enq", 1'b1, 1'b1, 5'd1);
    checkOutput("after_flush_enq.deq_bits", 64'(deq_bits), 64'h2A);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkStatus("after_flush_deq", 1'b1, 1'b0, 5'd0);

    // Full queue: only the dequeue fires, the enqueue lands next cycle.
    fillQueue(16, 'h60);
    applyStimulus(1'b1, 46'hAB, 1'b1, 1'b0);
    checkStatus("full_both", 1'b0, 1'b1, 5'd16);
    tick();
    checkStatus("full_after_deq", 1'b1, 1'b1, 5'd15);
    applyStimulus(1'b1, 46'hAB, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkStatus("full_refill", 1'b0, 1'b1, 5'd16);
    for (int i = 0; i < 16; i++) begin
      #1;
      checkOutput($sformatf("full_drain%0d.deq_bits", i), 64'(deq_bits),
                  (i < 15) ? 64'('h61 + i) : 64'hAB);
      tick();
    end
    checkStatus("full_drained", 1'b1, 1'b0, 5'd0);

    // Reset mid-transfer wins over a concurrent flush and enqueue.
    fillQueue(3, 'h30);
    reset = 1'b0;
    applyStimulus(1'b1, 46'h31, 1'b1, 1'b1);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkStatus("mid_reset", 1'b1, 1'b0, 5'd0);
    tick();
    checkStatus("mid_reset_idle", 1'b1, 1'b0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
